// File: rtl/nibble_serial_add_sequencer.sv
// Multi-cycle add/subtract unit for the ALU path: one 4-bit lookahead slice is
// reused across nibbles LSB first, with the inter-nibble carry held in a register.
module nibble_serial_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             sign,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  // Flattened lookahead: every carry depends only on p, g and the slice carry in.
  function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                      input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;

  logic [3:0] nib_a, nib_b, nib_p, nib_g, nib_c, nib_sum;
  logic       last_nib;

  assign nib_a    = opa_q[{idx_q, 2'b00} +: 4];
  assign nib_b    = opb_q[{idx_q, 2'b00} +: 4];
  assign nib_p    = nib_a ^ nib_b;
  assign nib_g    = nib_a & nib_b;
  assign nib_c    = cla4(nib_p, nib_g, cy_q);
  assign nib_sum  = nib_p ^ {nib_c[2:0], cy_q};
  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cy_d     = cy_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    if (state_q == S_RUN) begin
      acc_d[{idx_q, 2'b00} +: 4] = nib_sum;
      cy_d  = nib_c[3];
      idx_d = idx_q + 1'b1;
      if (last_nib) begin
        // Publish only the finished accumulator so partial sums never reach result.
        state_d  = S_DONE;
        idx_d    = '0;
        result_d = acc_d;
        carry_d  = nib_c[3];
        ovf_d    = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (acc_d[WIDTH-1] != opa_q[WIDTH-1]);
        sign_d   = acc_d[WIDTH-1];
        zero_d   = (acc_d == '0);
      end
    end else if (start) begin
      state_d = S_RUN;
      idx_d   = '0;
      opa_d   = a;
      opb_d   = op[1] ? ~b : b;
      unique case (op)
        OP_ADD:  cy_d = 1'b0;
        OP_ADC:  cy_d = c_in;
        OP_SUB:  cy_d = 1'b1;
        OP_SBC:  cy_d = c_in;
        default: cy_d = 1'b0;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    cy_q  <= cy_d;
    acc_q <= acc_d;
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign sign     = sign_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_nibble_serial_add_sequencer.sv
// Scoreboard bench for nibble_serial_add_sequencer: directed cases plus random
// operations checked against an integer-arithmetic reference model.
module tb_nibble_serial_add_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          c_in = 1'b0;
  logic          busy, done, carry, overflow, sign, zero;
  logic [W-1:0]  result;

  nibble_serial_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .sign(sign), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         cy;
    logic         ov;
    logic         s;
    logic         z;
    int           acc_edge;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  exp_t         dummy_e;
  int           errors = 0;
  int           checks = 0;
  int           edge_cnt = 0;
  int           done_cnt = 0;
  int           busy_run = 0;
  logic [W-1:0] held = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic ci);
    exp_t e;
    int ux, uy, sx, sy, k, full, ss;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    if (!o[1]) begin
      k    = (o == 2'b01) ? int'(ci) : 0;
      full = ux + uy + k;
      ss   = sx + sy + k;
      e.cy = (full > 65535);
    end else begin
      k    = (o == 2'b10) ? 0 : (ci ? 0 : 1);
      full = ux - uy - k;
      ss   = sx - sy - k;
      e.cy = (full >= 0);
    end
    e.r = full[W-1:0];
    e.ov = (ss > 32767) || (ss < -32768);
    e.s = e.r[W-1];
    e.z = (e.r == '0);
    e.acc_edge = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chk("reset outputs", {10'd0, busy, done, carry, overflow, sign, zero, result}, 32'd0);
      held = '0;
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected done", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("result", {16'd0, result}, {16'd0, mon_e.r});
          chk("carry", {31'd0, carry}, {31'd0, mon_e.cy});
          chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ov});
          chk("sign", {31'd0, sign}, {31'd0, mon_e.s});
          chk("zero", {31'd0, zero}, {31'd0, mon_e.z});
          chk("done latency", edge_cnt, mon_e.acc_edge + NIB);
          chk("busy cycles", busy_run, NIB);
        end
        held = result;
        busy_run = 0;
      end else begin
        chk("result held", {16'd0, result}, {16'd0, held});
        if (!busy) busy_run = 0;
      end
    end
  end

  task automatic drive_push(input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic ci);
    exp_t e;
    op = o; a = x; b = y; c_in = ci; start = 1'b1;
    e = model(o, x, y, ci);
    e.acc_edge = edge_cnt + 1;
    q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    drive_push(o, x, y, ci);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && done_cnt < target; i++) @(negedge clk);
    chk("done reached", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci);
    int t;
    t = done_cnt + 1;
    issue(o, x, y, ci);
    wait_done(t);
  endtask

  initial begin
    int t, first_done;
    logic [1:0] ro;
    logic [W-1:0] rx, ry;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 16'h1234, 16'h0FCD, 1'b0);
    chk("add 1234+0fcd", {16'd0, result}, 32'h2201);
    run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0);
    chk("add ffff+1 zero", {31'd0, zero}, 32'd1);
    run_op(2'b01, 16'h00FF, 16'h0000, 1'b1);
    chk("adc 00ff+0+1", {16'd0, result}, 32'h0100);
    run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0);
    chk("add 7fff+1 ovf", {31'd0, overflow}, 32'd1);
    run_op(2'b10, 16'h8000, 16'h0001, 1'b0);
    chk("sub 8000-1", {16'd0, result}, 32'h7FFF);
    run_op(2'b10, 16'h0005, 16'h0007, 1'b0);
    chk("sub 5-7 borrow", {31'd0, carry}, 32'd0);
    run_op(2'b11, 16'h0010, 16'h0001, 1'b0);
    chk("sbc 10-1-1", {16'd0, result}, 32'h000E);

    // A start pulse during RUN must not disturb the operation in flight.
    t = done_cnt + 1;
    issue(2'b00, 16'h1111, 16'h2222, 1'b0);
    start = 1'b1; op = 2'b10; a = 16'hAAAA; b = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    wait_done(t);
    chk("ignored start result", {16'd0, result}, 32'h3333);
    repeat (3) @(negedge clk);

    // Start held in the DONE cycle launches the next operation immediately.
    t = done_cnt;
    issue(2'b00, 16'h0102, 16'h0304, 1'b0);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    first_done = edge_cnt;
    drive_push(2'b10, 16'h1000, 16'h0001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(t + 2);
    chk("b2b spacing", edge_cnt, first_done + NIB + 1);
    chk("b2b second result", {16'd0, result}, 32'h0FFF);

    // Reset during the second RUN cycle aborts with no done pulse.
    t = done_cnt;
    issue(2'b00, 16'h4321, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    dummy_e = q.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no done after abort", done_cnt, t);
    run_op(2'b00, 16'h4321, 16'h1111, 1'b0);
    chk("op after abort", {16'd0, result}, 32'h5432);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 4) == 0) rx = 16'h8000;
      if ($urandom_range(0, 4) == 0) ry = 16'hFFFF;
      run_op(ro, rx, ry, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
